// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap controller: exception/interrupt/mret arbitration, CSR write sequencing, redirect.
// Optional TRAP_MTVAL_EN adds the WR_MTVAL state (mtval write of tval_i or 0).
module trap_ctrl #(
  parameter int DATA_W  = 64,
  parameter int IRQ_NUM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              except_src_if,
  input  logic              except_src_id,
  input  logic              except_src_ex,
  input  logic [3:0]        except_cus_if,
  input  logic [3:0]        except_cus_id,
  input  logic [3:0]        except_cus_ex,
  input  logic [DATA_W-1:0] pc_if,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [DATA_W-1:0] pc_ex,
  input  logic [DATA_W-1:0] tval_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic              mret_i,
  input  logic [DATA_W-1:0] csr_mtvec,
  input  logic [DATA_W-1:0] csr_mepc,
  input  logic [DATA_W-1:0] csr_mstatus,
  input  logic [DATA_W-1:0] csr_mie,
  output logic              csr_we_o,
  output logic [11:0]       csr_addr_o,
  output logic [DATA_W-1:0] csr_data_o,
  output logic              irq_assert_o,
  output logic [DATA_W-1:0] irq_addr_o,
  output logic              busy_o
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_WR_MEPC      = 3'd1;
  localparam logic [2:0] S_WR_MCAUSE    = 3'd2;
`ifdef TRAP_MTVAL_EN
  localparam logic [2:0] S_WR_MTVAL     = 3'd3;
`endif
  localparam logic [2:0] S_WR_MSTATUS   = 3'd4;
  localparam logic [2:0] S_ASSERT       = 3'd5;
  localparam logic [2:0] S_MRET_MSTATUS = 3'd6;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [DATA_W-1:0] r_cause;
  logic [DATA_W-1:0] r_epc;
  logic [DATA_W-1:0] r_target;
`ifdef TRAP_MTVAL_EN
  logic [DATA_W-1:0] r_tval;
`endif

  logic [IRQ_NUM-1:0] w_irq_pend;
  logic               w_irq_any;
  logic [4:0]         w_irq_code;
  logic               w_sel_exc;
  logic               w_sel_irq;
  logic               w_sel_mret;
  logic [3:0]         w_sel_cus;
  logic [DATA_W-1:0]  w_sel_pc;
  logic               w_req;
  logic               w_accept;
  logic [DATA_W-1:0]  w_base;
  logic [DATA_W-1:0]  w_target;
  logic [DATA_W-1:0]  w_cause;
  logic [DATA_W-1:0]  w_ms_trap;
  logic [DATA_W-1:0]  w_ms_mret;
  logic               w_unused;

`ifdef TRAP_MTVAL_EN
  assign w_unused = ^csr_mie;
`else
  assign w_unused = ^{csr_mie, tval_i};
`endif

  assign w_irq_pend = irq_i & csr_mie[16 +: IRQ_NUM] & {IRQ_NUM{csr_mstatus[3]}};
  assign w_irq_any  = |w_irq_pend;

  // Descending scan so the lowest pending channel is the last assignment and wins.
  always_comb begin
    w_irq_code = 5'd0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (w_irq_pend[k]) w_irq_code = 5'(16 + k);
    end
  end

  always_comb begin
    w_sel_exc  = 1'b0;
    w_sel_irq  = 1'b0;
    w_sel_mret = 1'b0;
    w_sel_cus  = 4'd0;
    w_sel_pc   = pc_id;
    if (except_src_ex) begin
      w_sel_exc = 1'b1;
      w_sel_cus = except_cus_ex;
      w_sel_pc  = pc_ex;
    end else if (except_src_id) begin
      w_sel_exc = 1'b1;
      w_sel_cus = except_cus_id;
      w_sel_pc  = pc_id;
    end else if (mret_i) begin
      w_sel_mret = 1'b1;
    end else if (except_src_if) begin
      w_sel_exc = 1'b1;
      w_sel_cus = except_cus_if;
      w_sel_pc  = pc_if;
    end else if (w_irq_any) begin
      w_sel_irq = 1'b1;
    end
  end

  assign w_req    = w_sel_exc | w_sel_irq | w_sel_mret;
  assign w_accept = rst_n & (r_state == S_IDLE) & ~hold_i & w_req;

  assign w_base = {csr_mtvec[DATA_W-1:2], 2'b00};

  always_comb begin
    w_target = w_base;
    if (w_sel_mret) begin
      w_target = csr_mepc;
    end else if (w_sel_irq && (csr_mtvec[1:0] == 2'b01)) begin
      w_target = w_base + {{(DATA_W-7){1'b0}}, w_irq_code, 2'b00};
    end
  end

  assign w_cause = w_sel_irq ? {1'b1, {(DATA_W-6){1'b0}}, w_irq_code}
                             : {{(DATA_W-4){1'b0}}, w_sel_cus};

  always_comb begin
    w_ms_trap        = csr_mstatus;
    w_ms_trap[12:11] = 2'b11;
    w_ms_trap[7]     = csr_mstatus[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_mret        = csr_mstatus;
    w_ms_mret[12:11] = 2'b11;
    w_ms_mret[7]     = 1'b1;
    w_ms_mret[3]     = csr_mstatus[7];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:         if (w_accept) w_next = w_sel_mret ? S_MRET_MSTATUS : S_WR_MEPC;
      S_WR_MEPC:      w_next = S_WR_MCAUSE;
`ifdef TRAP_MTVAL_EN
      S_WR_MCAUSE:    w_next = S_WR_MTVAL;
      S_WR_MTVAL:     w_next = S_WR_MSTATUS;
`else
      S_WR_MCAUSE:    w_next = S_WR_MSTATUS;
`endif
      S_WR_MSTATUS:   w_next = S_ASSERT;
      S_MRET_MSTATUS: w_next = S_ASSERT;
      S_ASSERT:       w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cause  <= '0;
      r_epc    <= '0;
      r_target <= '0;
`ifdef TRAP_MTVAL_EN
      r_tval   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cause  <= w_sel_mret ? '0 : w_cause;
        r_epc    <= w_sel_mret ? '0 : w_sel_pc;
        r_target <= w_target;
`ifdef TRAP_MTVAL_EN
        r_tval   <= w_sel_exc ? tval_i : '0;
`endif
      end
    end
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_addr_o   = 12'h000;
    csr_data_o   = '0;
    irq_assert_o = 1'b0;
    irq_addr_o   = '0;
    case (r_state)
      S_WR_MEPC: begin
        csr_we_o   = 1'b1;
        csr_addr_o = 12'h341;
        csr_data_o = r_epc;
      end
      S_WR_MCAUSE: begin
        csr_we_o   = 1'b1;
        csr_addr_o = 12'h342;
        csr_data_o = r_cause;
      end
`ifdef TRAP_MTVAL_EN
      S_WR_MTVAL: begin
        csr_we_o   = 1'b1;
        csr_addr_o = 12'h343;
        csr_data_o = r_tval;
      end
`endif
      S_WR_MSTATUS: begin
        csr_we_o   = 1'b1;
        csr_addr_o = 12'h300;
        csr_data_o = w_ms_trap;
      end
      S_MRET_MSTATUS: begin
        csr_we_o   = 1'b1;
        csr_addr_o = 12'h300;
        csr_data_o = w_ms_mret;
      end
      S_ASSERT: begin
        irq_assert_o = 1'b1;
        irq_addr_o   = r_target;
      end
      default: ;
    endcase
  end

  assign busy_o = (r_state != S_IDLE) | w_accept;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Multi-channel trap controller for the pipeline core: arbitrates stage exceptions (IF/ID/EX), `IRQ_NUM` level-sensitive external interrupt lines and `mret`. It serialises the machine-mode CSR updates over the single CSR write port, then issues a one-cycle redirect to `core_ctrl`. It sits between the pipeline stages, `reg_csr` and `ctrl`. It is the parametrised successor of the fixed single-source interrupt path, adding channel count, priority, vectored mode and an `mret` sequence.

## Interface
Parameters:
- `DATA_W`, 64, CSR/PC width.
- `IRQ_NUM`, 4, external interrupt channels (1..16).

Ports:
- `clk` in 1 — core clock.
- `rst_n` in 1 — asynchronous reset, active low.
- `hold_i` in 1 — pipeline stalled; no new trap is accepted while high.
- `except_src_if/id/ex` in 1 each — stage exception valid.
- `except_cus_if/id/ex` in 4 each — exception cause code.
- `pc_if/pc_id/pc_ex` in DATA_W each — PC of the instruction in that stage.
- `tval_i` in DATA_W — faulting address/instruction (used only with MTVAL).
- `irq_i` in IRQ_NUM — level interrupt requests.
- `mret_i` in 1 — `mret` decoded in ID.
- `csr_mtvec`, `csr_mepc`, `csr_mstatus`, `csr_mie` in DATA_W each — current CSR values.
- `csr_we_o` out 1 — CSR write strobe.
- `csr_addr_o` out 12 — CSR address.
- `csr_data_o` out DATA_W — CSR write data.
- `irq_assert_o` out 1 — redirect pulse.
- `irq_addr_o` out DATA_W — redirect target.
- `busy_o` out 1 — request to hold/flush the pipeline.

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, [WR_MTVAL], WR_MSTATUS, ASSERT, MRET_MSTATUS.
- **Arbitration in IDLE** (highest priority first):
  - `except_src_ex`, then `except_src_id`.
  - `mret_i`.
  - `except_src_if`.
  - Interrupts: channel k is pending when `irq_i[k] & csr_mie[16+k] & csr_mstatus[3]`. The lowest k wins.
- **Capture:** on acceptance, the controller registers the cause, the epc and the target.
  - Exception: mcause = {0, 59'b0, cus}; epc = PC of the faulting stage.
  - Interrupt: mcause = {1, (16+k)}; epc = `pc_id`.
- **Trap target:** base = {csr_mtvec[DATA_W-1:2], 2'b00}.
  - If csr_mtvec[1:0]==2'b01 and the trap is an interrupt, the target is base + 4*(16+k).
  - Otherwise the target is base.
- **Trap sequence:** WR_MEPC (0x341, epc) → WR_MCAUSE (0x342, mcause) → [WR_MTVAL] → WR_MSTATUS (0x300) → ASSERT → IDLE.
  - mstatus write: MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11, all other bits unchanged.
- **mret sequence:** MRET_MSTATUS (0x300: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11) → ASSERT, with target = `csr_mepc` sampled at acceptance.
- **Strobes:**
  - `csr_we_o` is high only in WR_* and MRET_MSTATUS states.
  - `irq_assert_o` is high only in ASSERT, with `irq_addr_o` = the registered target.
- **Inputs outside IDLE:** all requests are ignored outside IDLE. A captured interrupt completes even if `irq_i` drops mid-sequence.

## Timing
- **Reset values:** state IDLE, all outputs 0, all capture registers 0. Reset asserted mid-sequence aborts to IDLE immediately; no partial redirect is issued.
- **Acceptance:** a request is accepted in cycle T when the FSM is in IDLE and `hold_i`=0.
- **`busy_o`:** combinationally high in cycle T, then registered high through ASSERT inclusive. It is low in IDLE with no request.
- **Trap latency:**
  - WR_MEPC at T+1, WR_MCAUSE at T+2, WR_MSTATUS at T+3, ASSERT at T+4.
  - With MTVAL: WR_MTVAL at T+3, WR_MSTATUS at T+4, ASSERT at T+5.
- **mret latency:** MRET_MSTATUS at T+1, ASSERT at T+2.
- **Back-to-back:** a new request may be accepted in the cycle after ASSERT; there is no dead cycle beyond that.
- **Handshake:** one CSR write per cycle with no backpressure. `reg_csr` accepts every strobe.
- **Simultaneous requests:** only the highest-priority request is taken. Losers must remain asserted to be serviced later; the pipeline held by `busy_o` guarantees this for exceptions.

## Configuration
- `TRAP_MTVAL_EN` defined: adds the WR_MTVAL state, which writes 0x343 with `tval_i` for exceptions and 0 for interrupts. This adds one cycle of trap latency.
- `TRAP_MTVAL_EN` undefined: no WR_MTVAL state, `tval_i` is unused, and trap latency is 4 cycles.

## Test plan
- **EX exception:** `except_src_ex`=1, cus=5, pc_ex=0x8000_0010, mtvec=0x8000_0100.
  - Required: writes (0x341, 0x8000_0010), (0x342, 5), (0x300, MIE=0/MPIE=old MIE).
  - Required: `irq_assert_o` at T+4 with addr 0x8000_0100.
- **Vectored interrupt:** `irq_i[2]`=1, mie[18]=1, MIE=1, mtvec=0x8000_0101, pc_id=0x8000_0020.
  - Required: mcause=0x8000_0000_0000_0012, mepc=0x8000_0020, addr=0x8000_0148.
- **Priority:** ID exception, IF exception and `irq_i[0]` in the same cycle → only the ID exception is serviced. Holding all three afterwards, the IF exception is serviced next and the interrupt last.
- **mret:** `mret_i`=1, mepc=0x8000_0044, mstatus MPIE=1 / MIE=0 → write 0x300 with MIE=1, then `irq_assert_o` at T+2 with addr 0x8000_0044.
- **Hold and masking:**
  - `hold_i`=1 with `irq_i[1]` pending → no `busy_o` and no writes.
  - MIE=0 with `irq_i[1]` pending → never serviced.
- **Reset mid-operation:** `rst_n` low during WR_MCAUSE → all outputs 0 asynchronously. After release, no `irq_assert_o` is issued for the aborted trap.
